// File: rtl/mux_8x1_scan_ctrl.sv
// Select sequencer for a mux_8x1: steps s2/s1/s0 through all eight channels,
// samples y once per channel after a settle window and hands the byte downstream.
module mux_8x1_scan_ctrl #(
  parameter int unsigned SETTLE    = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     r_state;
  logic [2:0] r_sel;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_busy;

  logic [2:0] w_idx;
  logic [7:0] w_shift_next;

  // The byte including the bit captured on this edge, so the last channel
  // reaches data_out on the same edge that enters VALID.
  always_comb begin
    w_idx               = MSB_FIRST ? ~r_sel : r_sel;
    w_shift_next        = r_shift;
    w_shift_next[w_idx] = y_in;
  end

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; blocking = would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
      r_cnt   <= 4'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sel <= 3'd0;
          if (start) begin
            r_state <= SCAN;
            r_cnt   <= RELOAD;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_shift <= w_shift_next;
            if (r_sel != 3'd7) begin
              r_sel <= r_sel + 3'd1;
              r_cnt <= RELOAD;
            end else begin
              r_data  <= w_shift_next;
              r_valid <= 1'b1;
              r_state <= VALID;
            end
          end
        end
        VALID: begin
          if (ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_sel   <= 3'd0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= 3'd0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign {s2, s1, s0} = r_sel;
  assign busy         = r_busy;
  assign valid        = r_valid;
  assign data_out     = r_data;

endmodule

// File: tb/tb_mux_8x1_scan_ctrl.sv
// Directed bench for mux_8x1_scan_ctrl: three parameterisations, each driving
// a behavioural 8:1 mux from a fixed input pattern.
module tb_mux_8x1_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: SETTLE=1 LSB-first, b: SETTLE=1 MSB-first, c: SETTLE=3 LSB-first
  logic       rst_a, start_a, ready_a, y_a, s2_a, s1_a, s0_a, busy_a, valid_a;
  logic       rst_b, start_b, ready_b, y_b, s2_b, s1_b, s0_b, busy_b, valid_b;
  logic       rst_c, start_c, ready_c, y_c, s2_c, s1_c, s0_c, busy_c, valid_c;
  logic [7:0] data_a, data_b, data_c;
  logic [7:0] pat_a, pat_b, pat_c;

  assign y_a = pat_a[{s2_a, s1_a, s0_a}];
  assign y_b = pat_b[{s2_b, s1_b, s0_b}];
  assign y_c = pat_c[{s2_c, s1_c, s0_c}];

  mux_8x1_scan_ctrl #(.SETTLE(1), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .y_in(y_a),
    .s2(s2_a), .s1(s1_a), .s0(s0_a), .busy(busy_a),
    .data_out(data_a), .valid(valid_a), .ready(ready_a));

  mux_8x1_scan_ctrl #(.SETTLE(1), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .y_in(y_b),
    .s2(s2_b), .s1(s1_b), .s0(s0_b), .busy(busy_b),
    .data_out(data_b), .valid(valid_b), .ready(ready_b));

  mux_8x1_scan_ctrl #(.SETTLE(3), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst_c), .start(start_c), .y_in(y_c),
    .s2(s2_c), .s1(s1_c), .s0(s0_c), .busy(busy_c),
    .data_out(data_c), .valid(valid_c), .ready(ready_c));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs changed and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; ready_a = 1'b1; pat_a = 8'hA5;
    rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b1; pat_b = 8'h01;
    rst_c = 1'b1; start_c = 1'b0; ready_c = 1'b0; pat_c = 8'h3C;
    #1;

    // Reset, then idle
    tick(); tick();
    check("rst_sel",   {5'd0, s2_a, s1_a, s0_a}, 8'd0);
    check("rst_busy",  {7'd0, busy_a}, 8'd0);
    check("rst_valid", {7'd0, valid_a}, 8'd0);
    check("rst_data",  data_a, 8'h00);
    check("rst_data_c", data_c, 8'h00);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_busy", {7'd0, busy_a}, 8'd0);
    end
    check("idle_sel",  {5'd0, s2_a, s1_a, s0_a}, 8'd0);
    check("idle_valid", {7'd0, valid_a}, 8'd0);
    check("idle_data", data_a, 8'h00);

    // Basic scan, SETTLE=1, LSB-first, pattern A5
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_busy0", {7'd0, busy_a}, 8'd1);
    check("a_sel0",  {5'd0, s2_a, s1_a, s0_a}, 8'd0);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("a_sel_step", {5'd0, s2_a, s1_a, s0_a}, 8'(k));
      check("a_no_valid", {7'd0, valid_a}, 8'd0);
    end
    tick();
    check("a_valid", {7'd0, valid_a}, 8'd1);
    check("a_data",  data_a, 8'hA5);
    check("a_sel7",  {5'd0, s2_a, s1_a, s0_a}, 8'd7);
    tick();
    check("a_done_valid", {7'd0, valid_a}, 8'd0);
    check("a_done_busy",  {7'd0, busy_a}, 8'd0);
    check("a_done_sel",   {5'd0, s2_a, s1_a, s0_a}, 8'd0);
    check("a_hold_data",  data_a, 8'hA5);

    // MSB-first, channel 0 high -> bit 7
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    check("b_no_valid_7", {7'd0, valid_b}, 8'd0);
    tick();
    check("b_valid", {7'd0, valid_b}, 8'd1);
    check("b_data",  data_b, 8'h80);
    tick();
    check("b_idle", {7'd0, busy_b}, 8'd0);

    // SETTLE=3, pattern 3C, with backpressure at completion
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("c_sel0", {5'd0, s2_c, s1_c, s0_c}, 8'd0);
    for (int e = 1; e < 24; e++) begin
      tick();
      check("c_sel_hold", {5'd0, s2_c, s1_c, s0_c}, 8'(e / 3));
      check("c_no_valid", {7'd0, valid_c}, 8'd0);
    end
    tick();
    check("c_valid", {7'd0, valid_c}, 8'd1);
    check("c_data",  data_c, 8'h3C);
    for (int i = 0; i < 10; i++) begin
      start_c = i[0];
      tick();
      check("bp_valid", {7'd0, valid_c}, 8'd1);
      check("bp_data",  data_c, 8'h3C);
      check("bp_sel",   {5'd0, s2_c, s1_c, s0_c}, 8'd7);
    end
    // start on the handshake edge must be ignored
    ready_c = 1'b1; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("c_ack_valid", {7'd0, valid_c}, 8'd0);
    check("c_ack_busy",  {7'd0, busy_c}, 8'd0);
    tick();
    check("c_start_ignored", {7'd0, busy_c}, 8'd0);
    check("c_hold_data", data_c, 8'h3C);

    // Reset mid-scan, then a full scan of FF
    pat_a = 8'hFF;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("mid_sel4",  {5'd0, s2_a, s1_a, s0_a}, 8'd4);
    check("mid_data_held", data_a, 8'hA5);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("mid_rst_sel",  {5'd0, s2_a, s1_a, s0_a}, 8'd0);
    check("mid_rst_busy", {7'd0, busy_a}, 8'd0);
    check("mid_rst_data", data_a, 8'h00);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    check("ff_no_valid_7", {7'd0, valid_a}, 8'd0);
    tick();
    check("ff_valid", {7'd0, valid_a}, 8'd1);
    check("ff_data",  data_a, 8'hFF);
    tick();
    check("ff_idle", {7'd0, busy_a}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
